// File: rtl/port_flow_controller.sv
// Input-port flow controller for a mesh NoC switch.
// Decodes the head flit at the FIFO front, computes the XY route, reserves the
// output through the switch, then streams multi-phit packets downstream.
// Body/tail flits that arrive with no open route are popped and flagged.
module port_flow_controller #(
    parameter int unsigned N             = 4,
    parameter int unsigned INDEX         = 1,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned TYPE_WIDTH    = 2,
    parameter int unsigned REQUEST_WIDTH = 3,
    parameter int unsigned PhitPerFlit   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    output logic                     ready_in,
    output logic                     pushBuffer,
    input  logic                     full,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     empty,
    output logic                     popBuffer,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic                     routeReserveRequestValid,
    output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic                     routeReserveStatus,
    output logic                     routeRelieve,
    output logic                     dropFlit
);

    localparam int unsigned DestWidth = $clog2(N * N);
    localparam int unsigned CntWidth  = $clog2(PhitPerFlit) + 1;
    localparam int unsigned MyX       = INDEX % N;
    localparam int unsigned MyY       = INDEX / N;

    localparam logic [TYPE_WIDTH-1:0] TypeHead     = TYPE_WIDTH'(0);
    localparam logic [TYPE_WIDTH-1:0] TypeBody     = TYPE_WIDTH'(1);
    localparam logic [TYPE_WIDTH-1:0] TypeTail     = TYPE_WIDTH'(2);
    localparam logic [TYPE_WIDTH-1:0] TypeHeadTail = TYPE_WIDTH'(3);

    localparam logic [REQUEST_WIDTH-1:0] DirNorth = REQUEST_WIDTH'(0);
    localparam logic [REQUEST_WIDTH-1:0] DirSouth = REQUEST_WIDTH'(1);
    localparam logic [REQUEST_WIDTH-1:0] DirWest  = REQUEST_WIDTH'(2);
    localparam logic [REQUEST_WIDTH-1:0] DirEast  = REQUEST_WIDTH'(3);
    localparam logic [REQUEST_WIDTH-1:0] DirLocal = REQUEST_WIDTH'(4);

    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(PhitPerFlit - 1);

    typedef enum logic [2:0] {StIdle, StReq, StXfer, StRls, StDrop} state_e;

    state_e                   state_q, state_d;
    logic [CntWidth-1:0]      cnt_q, cnt_d;
    logic [REQUEST_WIDTH-1:0] dir_q, dir_d;
    logic [TYPE_WIDTH-1:0]    type_q, type_d;
    logic                     drop_q, drop_d;

    logic [TYPE_WIDTH-1:0]    front_type;
    logic [DestWidth-1:0]     dest_idx;
    logic [REQUEST_WIDTH-1:0] route_dir;
    logic [TYPE_WIDTH-1:0]    cur_type;
    logic                     handshake;
    int unsigned              dest_x, dest_y;
    logic                     unused_data;

    assign front_type  = data_in[DATA_WIDTH-1 -: TYPE_WIDTH];
    assign dest_idx    = data_in[DestWidth-1:0];
    assign unused_data = ^data_in;

    // Upstream side is purely combinational and held off during reset.
    assign ready_in   = ~full & rst;
    assign pushBuffer = valid_in & ready_in;

    assign dropFlit = drop_q;

    // XY route of the destination carried by the front phit.
    always_comb begin
        dest_x = 32'(dest_idx) % N;
        dest_y = 32'(dest_idx) / N;
        if (dest_x != MyX) begin
            route_dir = (dest_x > MyX) ? DirEast : DirWest;
        end else if (dest_y != MyY) begin
            route_dir = (dest_y > MyY) ? DirSouth : DirNorth;
        end else begin
            route_dir = DirLocal;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d                  = state_q;
        cnt_d                    = cnt_q;
        dir_d                    = dir_q;
        type_d                   = type_q;
        drop_d                   = 1'b0;
        valid_out                = 1'b0;
        popBuffer                = 1'b0;
        routeReserveRequestValid = 1'b0;
        routeReserveRequest      = '0;
        routeRelieve             = 1'b0;
        handshake                = 1'b0;
        // Phit 0 carries the type, so use it live before it is latched.
        cur_type                 = (cnt_q == '0) ? front_type : type_q;

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    if (front_type == TypeHead || front_type == TypeHeadTail) begin
                        dir_d   = route_dir;
                        state_d = StReq;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StReq: begin
                routeReserveRequestValid = 1'b1;
                routeReserveRequest      = dir_q;
                if (routeReserveStatus) begin
                    state_d = StXfer;
                end
            end
            StXfer: begin
                valid_out = ~empty;
                handshake = valid_out & ready_out;
                popBuffer = handshake;
                if (handshake) begin
                    if (cnt_q == '0) begin
                        type_d = front_type;
                    end
                    if (cnt_q == LastCnt) begin
                        cnt_d = '0;
                        if (cur_type == TypeTail || cur_type == TypeHeadTail) begin
                            state_d = StRls;
                        end
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
            end
            StRls: begin
                routeRelieve = 1'b1;
                state_d      = StIdle;
            end
            StDrop: begin
                popBuffer = ~empty;
                if (!empty) begin
                    if (cnt_q == LastCnt) begin
                        cnt_d   = '0;
                        drop_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            dir_q   <= '0;
            type_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            type_q  <= type_d;
            drop_q  <= drop_d;
        end
    end

    // Body type is decoded only for readability of the flit encoding.
    logic unused_type_body;
    assign unused_type_body = (TypeBody == TypeHead);

endmodule

// File: tb/tb_port_flow_controller.sv
// Directed bench for port_flow_controller (N=4, INDEX=5, PhitPerFlit=2).
// The FIFO is modelled as a queue; data_in/empty follow its front.
module tb_port_flow_controller;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic       ready_in;
    logic       pushBuffer;
    logic       full;
    logic [7:0] data_in;
    logic       empty;
    logic       popBuffer;
    logic       valid_out;
    logic       ready_out;
    logic       routeReserveRequestValid;
    logic [2:0] routeReserveRequest;
    logic       routeReserveStatus;
    logic       routeRelieve;
    logic       dropFlit;

    port_flow_controller #(
        .N            (4),
        .INDEX        (5),
        .DATA_WIDTH   (8),
        .TYPE_WIDTH   (2),
        .REQUEST_WIDTH(3),
        .PhitPerFlit  (2)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .valid_in                (valid_in),
        .ready_in                (ready_in),
        .pushBuffer              (pushBuffer),
        .full                    (full),
        .data_in                 (data_in),
        .empty                   (empty),
        .popBuffer               (popBuffer),
        .valid_out               (valid_out),
        .ready_out               (ready_out),
        .routeReserveRequestValid(routeReserveRequestValid),
        .routeReserveRequest     (routeReserveRequest),
        .routeReserveStatus      (routeReserveStatus),
        .routeRelieve            (routeRelieve),
        .dropFlit                (dropFlit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] THead = 2'd0;
    localparam logic [1:0] TBody = 2'd1;
    localparam logic [1:0] TTail = 2'd2;
    localparam logic [1:0] THt   = 2'd3;

    logic [7:0] fifo[$];
    int checks = 0;
    int passes = 0;

    // Per-cycle event counters, sampled on the falling edge.
    int pop_cnt  = 0;
    int vo_cnt   = 0;
    int req_cnt  = 0;
    int drop_cnt = 0;

    always @(negedge clk) begin
        pop_cnt  <= pop_cnt + int'(popBuffer);
        vo_cnt   <= vo_cnt + int'(valid_out);
        req_cnt  <= req_cnt + int'(routeReserveRequestValid);
        drop_cnt <= drop_cnt + int'(dropFlit);
    end

    typedef struct {
        logic [3:0] dest;
        logic [2:0] exp_req;
        string      name;
    } vec_t;

    vec_t vecs[5];

    function automatic logic [7:0] ph(input logic [1:0] t, input logic [3:0] d);
        return {t, 2'b00, d};
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic checkv(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive_fifo();
        empty   = (fifo.size() == 0);
        data_in = empty ? 8'h00 : fifo[0];
    endtask

    // One clock: pop decided by the pre-edge popBuffer, inputs settled after.
    task automatic tick();
        logic pop;
        pop = popBuffer;
        @(posedge clk);
        #1;
        if (pop && fifo.size() > 0) void'(fifo.pop_front());
        drive_fifo();
        #1;
    endtask

    task automatic load(input logic [7:0] p0, input logic [7:0] p1);
        fifo.push_back(p0);
        fifo.push_back(p1);
        drive_fifo();
        #1;
    endtask

    task automatic grant_now();
        routeReserveStatus = 1'b1;
        tick();
        routeReserveStatus = 1'b0;
    endtask

    // Run until routeRelieve (bounded), then step into IDLE.
    task automatic drain(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (routeRelieve) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check1(name, seen, 1'b1);
        tick();
    endtask

    initial begin
        int b_pop, b_vo, b_req, b_drop;

        vecs[0] = '{dest: 4'd7,  exp_req: 3'd3, name: "xy_east"};
        vecs[1] = '{dest: 4'd4,  exp_req: 3'd2, name: "xy_west"};
        vecs[2] = '{dest: 4'd13, exp_req: 3'd1, name: "xy_south"};
        vecs[3] = '{dest: 4'd1,  exp_req: 3'd0, name: "xy_north"};
        vecs[4] = '{dest: 4'd5,  exp_req: 3'd4, name: "xy_local"};

        rst                = 1'b0;
        valid_in           = 1'b0;
        full               = 1'b0;
        ready_out          = 1'b1;
        routeReserveStatus = 1'b0;
        drive_fifo();
        #1;
        tick();
        tick();

        // Reset state
        check1("rst_valid_out", valid_out, 1'b0);
        check1("rst_pop", popBuffer, 1'b0);
        check1("rst_req_valid", routeReserveRequestValid, 1'b0);
        checkv("rst_req", 32'(routeReserveRequest), 0);
        check1("rst_relieve", routeRelieve, 1'b0);
        check1("rst_drop", dropFlit, 1'b0);
        check1("rst_ready_in", ready_in, 1'b0);
        check1("rst_push", pushBuffer, 1'b0);
        rst = 1'b1;
        #1;
        check1("post_rst_ready_in", ready_in, 1'b1);
        tick();

        // Local 3-flit packet, grant one cycle after the request
        load(ph(THead, 4'd5), 8'h11);
        load(ph(TBody, 4'd0), 8'h22);
        load(ph(TTail, 4'd0), 8'h33);
        check1("t1_idle_no_req", routeReserveRequestValid, 1'b0);
        tick();
        check1("t1_req_valid", routeReserveRequestValid, 1'b1);
        checkv("t1_req_dir", 32'(routeReserveRequest), 4);
        tick();
        check1("t1_req_held", routeReserveRequestValid, 1'b1);
        grant_now();
        for (int i = 0; i < 6; i++) begin
            check1($sformatf("t1_hs%0d", i), valid_out & ready_out, 1'b1);
            tick();
        end
        check1("t1_relieve", routeRelieve, 1'b1);
        check1("t1_rls_no_valid", valid_out, 1'b0);
        tick();
        check1("t1_relieve_once", routeRelieve, 1'b0);

        // XY direction table
        foreach (vecs[k]) begin
            load(ph(THt, vecs[k].dest), 8'h5a);
            tick();
            check1({vecs[k].name, "_valid"}, routeReserveRequestValid, 1'b1);
            checkv(vecs[k].name, 32'(routeReserveRequest), 32'(vecs[k].exp_req));
            grant_now();
            drain({vecs[k].name, "_release"});
        end

        // HEADTAIL with grant withheld and ready_out stalls
        load(ph(THt, 4'd6), 8'h66);
        tick();
        for (int i = 0; i < 6; i++) begin
            check1($sformatf("t3_req_held%0d", i), routeReserveRequestValid, 1'b1);
            checkv($sformatf("t3_req_dir%0d", i), 32'(routeReserveRequest), 3);
            if (i == 5) grant_now();
            else tick();
        end
        ready_out = 1'b1;
        #1;
        check1("t3_pop_r1", popBuffer, 1'b1);
        tick();
        ready_out = 1'b0;
        #1;
        check1("t3_pop_r0", popBuffer, 1'b0);
        check1("t3_valid_r0", valid_out, 1'b1);
        tick();
        ready_out = 1'b1;
        #1;
        check1("t3_pop_r1b", popBuffer, 1'b1);
        tick();
        check1("t3_relieve", routeRelieve, 1'b1);
        tick();

        // Malformed BODY flit is discarded
        load(ph(TBody, 4'd3), 8'h77);
        b_pop  = pop_cnt;
        b_vo   = vo_cnt;
        b_req  = req_cnt;
        b_drop = drop_cnt;
        check1("t4_idle_no_pop", popBuffer, 1'b0);
        tick();
        tick();
        tick();
        check1("t4_drop_pulse", dropFlit, 1'b1);
        tick();
        checkv("t4_pops", pop_cnt - b_pop, 2);
        checkv("t4_valid_out", vo_cnt - b_vo, 0);
        checkv("t4_no_req", req_cnt - b_req, 0);
        checkv("t4_drop_count", drop_cnt - b_drop, 1);
        load(ph(THt, 4'd13), 8'h88);
        tick();
        check1("t4_next_req_valid", routeReserveRequestValid, 1'b1);
        checkv("t4_next_req_dir", 32'(routeReserveRequest), 1);
        grant_now();
        drain("t4_next_release");

        // Empty bubble between BODY and TAIL
        load(ph(THead, 4'd4), 8'h01);
        load(ph(TBody, 4'd0), 8'h02);
        tick();
        checkv("t5_req_dir", 32'(routeReserveRequest), 2);
        grant_now();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 4; i++) begin
            check1($sformatf("t5_bubble_valid%0d", i), valid_out, 1'b0);
            check1($sformatf("t5_bubble_rls%0d", i), routeRelieve, 1'b0);
            check1($sformatf("t5_bubble_req%0d", i), routeReserveRequestValid, 1'b0);
            tick();
        end
        load(ph(TTail, 4'd0), 8'h03);
        check1("t5_resume_valid", valid_out, 1'b1);
        drain("t5_release");

        // Full FIFO blocks the upstream link
        valid_in = 1'b1;
        full     = 1'b1;
        #1;
        check1("t5_full_ready_in", ready_in, 1'b0);
        check1("t5_full_push", pushBuffer, 1'b0);
        full = 1'b0;
        #1;
        check1("t5_notfull_push", pushBuffer, 1'b1);
        valid_in = 1'b0;
        tick();

        // Reset in the middle of a packet
        load(ph(THead, 4'd5), 8'h10);
        load(ph(TBody, 4'd0), 8'h20);
        load(ph(TBody, 4'd0), 8'h30);
        load(ph(TTail, 4'd0), 8'h40);
        tick();
        grant_now();
        for (int i = 0; i < 4; i++) tick();
        check1("t6_mid_valid", valid_out, 1'b1);
        rst      = 1'b0;
        valid_in = 1'b1;
        #1;
        tick();
        fifo.delete();
        load(ph(THt, 4'd1), 8'h50);
        check1("t6_rst_valid_out", valid_out, 1'b0);
        check1("t6_rst_pop", popBuffer, 1'b0);
        check1("t6_rst_req_valid", routeReserveRequestValid, 1'b0);
        check1("t6_rst_relieve", routeRelieve, 1'b0);
        check1("t6_rst_drop", dropFlit, 1'b0);
        check1("t6_rst_ready_in", ready_in, 1'b0);
        check1("t6_rst_push", pushBuffer, 1'b0);
        valid_in = 1'b0;
        rst      = 1'b1;
        #1;
        check1("t6_idle_after_rst", routeReserveRequestValid, 1'b0);
        tick();
        check1("t6_new_req_valid", routeReserveRequestValid, 1'b1);
        checkv("t6_new_req_dir", 32'(routeReserveRequest), 0);
        grant_now();
        drain("t6_new_release");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
